// File: rtl/base_framer.sv
// base_framer: transmit-side stream framer.
// Accepts a (len, tag) burst request on a valid/ready port and emits len beats
// on a valid/ready/end stream, tagging every beat and flagging the final one.
// A len of 0 encodes the maximum burst of 2^lwidth beats.
module base_framer #(
  parameter int lwidth = 8,
  parameter int twidth = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_v,
  output logic              i_req_r,
  input  logic [lwidth-1:0] i_req_len,
  input  logic [twidth-1:0] i_req_tag,
  output logic              o_v,
  input  logic              o_r,
  output logic              o_e,
  output logic [twidth-1:0] o_tag,
  output logic [lwidth-1:0] o_cnt,
  output logic              o_act
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [lwidth-1:0] ONE = lwidth'(1);

  logic [0:0]        state_q;
  logic [lwidth-1:0] len_q;
  logic [lwidth-1:0] cnt_q;
  logic [twidth-1:0] tag_q;
  logic              e_q;

  logic              req_acc;
  logic              beat_take;
  logic [lwidth-1:0] cnt_inc;

  // Handshake decode; ready depends only on state, o_r and the end flag, so
  // a new burst can be accepted in the same cycle the final beat is taken.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path; a missing
    // default would infer a latch.
    i_req_r   = 1'b0;
    beat_take = 1'b0;
    cnt_inc   = cnt_q + ONE;
    if (reset) begin
      i_req_r = (state_q == IDLE) | ((state_q == SEND) & o_r & e_q);
    end
    beat_take = (state_q == SEND) & o_r;
  end

  assign req_acc = i_req_v & i_req_r;

  // Burst sequencer: latches the request, steps the beat index, and
  // precomputes the end flag so every stream output comes from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments keep all flops updating from the
      // pre-edge values, which is what the back-to-back handoff relies on.
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      e_q     <= 1'b0;
    end else if (req_acc) begin
      // New burst (from IDLE, or overlapping the final beat of the previous).
      state_q <= SEND;
      len_q   <= i_req_len;
      tag_q   <= i_req_tag;
      cnt_q   <= '0;
      // Index 0 is final only for a one-beat burst.
      e_q     <= (i_req_len == ONE);
    end else if (beat_take) begin
      if (e_q) begin
        state_q <= IDLE;
        e_q     <= 1'b0;
      end else begin
        cnt_q <= cnt_inc;
        // Modulo arithmetic makes len 0 end at index 2^lwidth - 1.
        e_q   <= (cnt_inc == (len_q - ONE));
      end
    end
  end

  assign o_v   = (state_q == SEND);
  assign o_act = (state_q == SEND);
  assign o_e   = e_q;
  assign o_tag = tag_q;
  assign o_cnt = cnt_q;

endmodule

// File: tb/tb_base_framer.sv
// tb_base_framer: scoreboard bench for base_framer. Each accepted request
// pushes its expected beats; a negedge monitor pops and compares every beat
// the sink takes. Scenario tasks add their own timing/handshake checks.
module tb_base_framer;

  logic       clk;
  logic       reset;
  logic       i_req_v;
  logic       i_req_r;
  logic [7:0] i_req_len;
  logic [3:0] i_req_tag;
  logic       o_v;
  logic       o_r;
  logic       o_e;
  logic [3:0] o_tag;
  logic [7:0] o_cnt;
  logic       o_act;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] cnt;
    logic       e;
  } beat_t;

  beat_t sb[$];
  int    n_checks;
  int    n_fail;
  int    cyc;
  int    last_acc;

  base_framer #(.lwidth(8), .twidth(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req_v   (i_req_v),
    .i_req_r   (i_req_r),
    .i_req_len (i_req_len),
    .i_req_tag (i_req_tag),
    .o_v       (o_v),
    .o_r       (o_r),
    .o_e       (o_e),
    .o_tag     (o_tag),
    .o_cnt     (o_cnt),
    .o_act     (o_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor: stream invariants every cycle, scoreboard compare on take.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      n_checks++;
      if (o_act !== o_v) begin
        n_fail++;
        $display("FAIL act_eq_v: o_act=%b o_v=%b", o_act, o_v);
      end
      n_checks++;
      if (o_e === 1'b1 && o_v !== 1'b1) begin
        n_fail++;
        $display("FAIL e_without_v: o_e=%b o_v=%b", o_e, o_v);
      end
      if (o_v === 1'b1 && o_r === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got tag=%0d cnt=%0d e=%b, expected none",
                   o_tag, o_cnt, o_e);
        end else begin
          beat_t exp_b;
          exp_b = sb.pop_front();
          if (o_tag !== exp_b.tag || o_cnt !== exp_b.cnt || o_e !== exp_b.e) begin
            n_fail++;
            $display("FAIL beat: got tag=%0d cnt=%0d e=%b, expected tag=%0d cnt=%0d e=%b",
                     o_tag, o_cnt, o_e, exp_b.tag, exp_b.cnt, exp_b.e);
          end
        end
      end
    end
  end

  // Offer a request and hold it until accepted; push its beats on acceptance.
  task automatic req(input logic [7:0] len, input logic [3:0] tag);
    bit ok;
    int n;
    beat_t b;
    ok        = 1'b0;
    i_req_v   = 1'b1;
    i_req_len = len;
    i_req_tag = tag;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (i_req_r === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL req_accept: len=%0d tag=%0d not accepted within 1000 cycles, expected acceptance",
               len, tag);
    end else begin
      n = (len == 8'd0) ? 256 : int'(len);
      for (int i = 0; i < n; i++) begin
        b.tag = tag;
        b.cnt = i[7:0];
        b.e   = (i == n - 1);
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    i_req_v  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({o_v, o_e, o_act, o_cnt, o_tag, i_req_r} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_values: v=%b e=%b act=%b cnt=%0d tag=%0d rdy=%b, expected all 0",
               o_v, o_e, o_act, o_cnt, o_tag, i_req_r);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (i_req_r !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: i_req_r=%b, expected 1", i_req_r);
    end
  endtask

  task automatic test_single();
    o_r = 1'b1;
    req(8'd3, 4'd5);
    n_checks++;
    if (o_v !== 1'b1 || o_cnt !== 8'd0 || o_tag !== 4'd5) begin
      n_fail++;
      $display("FAIL single_first: v=%b cnt=%0d tag=%0d, expected v=1 cnt=0 tag=5",
               o_v, o_cnt, o_tag);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_v !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: o_v=%b at N+4, expected 0", o_v);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    o_r = 1'b1;
    req(8'd2, 4'd1);
    a = last_acc;
    req(8'd1, 4'd2);
    n_checks++;
    if (last_acc !== a + 2) begin
      n_fail++;
      $display("FAIL b2b_accept_cycle: accepted at +%0d, expected +2", last_acc - a);
    end
    n_checks++;
    if (o_v !== 1'b1 || o_tag !== 4'd2 || o_cnt !== 8'd0 || o_e !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b tag=%0d cnt=%0d e=%b, expected v=1 tag=2 cnt=0 e=1",
               o_v, o_tag, o_cnt, o_e);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (o_v !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: o_v=%b, expected 0", o_v);
    end
  endtask

  task automatic test_backpressure();
    logic [14:0] snap;
    o_r = 1'b0;
    req(8'd4, 4'd3);
    for (int k = 0; k < 8; k++) begin
      o_r = k[0];
      #1;
      n_checks++;
      if (i_req_r !== (o_r & o_e)) begin
        n_fail++;
        $display("FAIL bp_ready: k=%0d i_req_r=%b, expected %b", k, i_req_r, o_r & o_e);
      end
      snap = {o_v, o_e, o_tag, o_cnt, o_act};
      @(posedge clk);
      #1;
      if (k[0] == 1'b0) begin
        n_checks++;
        if ({o_v, o_e, o_tag, o_cnt, o_act} !== snap) begin
          n_fail++;
          $display("FAIL bp_hold: k=%0d got %h, expected %h", k,
                   {o_v, o_e, o_tag, o_cnt, o_act}, snap);
        end
      end
    end
    n_checks++;
    if (o_v !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: o_v=%b after 8 cycles, expected 0", o_v);
    end
    o_r = 1'b1;
  endtask

  task automatic test_max_len();
    o_r = 1'b1;
    req(8'd0, 4'd7);
    repeat (255) @(posedge clk);
    #1;
    n_checks++;
    if (o_v !== 1'b1 || o_cnt !== 8'd255 || o_e !== 1'b1) begin
      n_fail++;
      $display("FAIL max_last: v=%b cnt=%0d e=%b, expected v=1 cnt=255 e=1", o_v, o_cnt, o_e);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (o_v !== 1'b0) begin
      n_fail++;
      $display("FAIL max_end: o_v=%b after 256 beats, expected 0", o_v);
    end
  endtask

  task automatic test_len1_stall();
    int c0;
    o_r = 1'b0;
    req(8'd1, 4'd9);
    c0        = last_acc;
    i_req_v   = 1'b1;
    i_req_len = 8'd2;
    i_req_tag = 4'd10;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (o_v !== 1'b1 || o_e !== 1'b1 || o_tag !== 4'd9 || i_req_r !== 1'b0) begin
        n_fail++;
        $display("FAIL len1_stall: k=%0d v=%b e=%b tag=%0d rdy=%b, expected v=1 e=1 tag=9 rdy=0",
                 k, o_v, o_e, o_tag, i_req_r);
      end
      @(posedge clk);
      #1;
    end
    o_r = 1'b1;
    req(8'd2, 4'd10);
    n_checks++;
    if (last_acc !== c0 + 4) begin
      n_fail++;
      $display("FAIL len1_accept_cycle: accepted at +%0d, expected +4", last_acc - c0);
    end
    n_checks++;
    if (o_v !== 1'b1 || o_tag !== 4'd10 || o_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL len1_next: v=%b tag=%0d cnt=%0d, expected v=1 tag=10 cnt=0",
               o_v, o_tag, o_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    o_r = 1'b1;
    req(8'd6, 4'd4);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_cnt !== 8'd2 || o_v !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: cnt=%0d v=%b, expected cnt=2 v=1", o_cnt, o_v);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (o_v !== 1'b0 || o_e !== 1'b0 || o_act !== 1'b0 || i_req_r !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: v=%b e=%b act=%b rdy=%b, expected all 0",
               o_v, o_e, o_act, i_req_r);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    req(8'd2, 4'd8);
    n_checks++;
    if (o_v !== 1'b1 || o_cnt !== 8'd0 || o_tag !== 4'd8) begin
      n_fail++;
      $display("FAIL rst_mid_fresh: v=%b cnt=%0d tag=%0d, expected v=1 cnt=0 tag=8",
               o_v, o_cnt, o_tag);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    last_acc  = 0;
    reset     = 1'b0;
    i_req_v   = 1'b0;
    i_req_len = 8'd0;
    i_req_tag = 4'd0;
    o_r       = 1'b0;

    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_max_len();
    test_len1_stall();
    test_reset_mid();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d beats outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
